// File: rtl/memory_stage.sv
// MEM stage: EX/MEM and MEM/WB pipeline registers around a word data-memory
// access with req/ready handshake, stall, timeout abort and misalign trap.
module memory_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteE,
  input  logic        MemWriteE,
  input  logic [1:0]  MemtoRegE,
  input  logic        jumpE,
  input  logic [4:0]  WriteRegE,
  input  logic [31:0] ALUMultOutE,
  input  logic [31:0] WriteDataE,
  input  logic [31:0] PCPlus4E,
  output logic [31:0] ALUOutM,
  output logic [4:0]  WriteRegM,
  output logic        RegWriteM,
  output logic [1:0]  MemtoRegM,
  output logic        StallM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        RegWriteW,
  output logic        jumpW,
  output logic [1:0]  MemtoRegW,
  output logic [4:0]  WriteRegW,
  output logic [31:0] ALUOutW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic [1:0]  MemErr
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state, stateNext;
  logic [CNT_W-1:0]  cnt;
  logic              MemWriteM, jumpM;
  logic [31:0]       WriteDataM, PCPlus4M;
  logic              memAccE, alignAccE;
  logic              memAccM, misM;
  logic              waitSt, lastCyc, abortM;

  assign memAccE   = MemWriteE | (MemtoRegE == 2'b01);
  assign alignAccE = memAccE & (ALUMultOutE[1:0] == 2'b00);
  assign memAccM   = MemWriteM | (MemtoRegM == 2'b01);
  assign misM      = memAccM & (ALUOutM[1:0] != 2'b00);

  assign waitSt  = (state == WAIT);
  assign lastCyc = (cnt == CNT_W'(TIMEOUT - 1));
  assign StallM  = waitSt & ~mem_ready & ~lastCyc;
  assign abortM  = waitSt & ~mem_ready & lastCyc;

  assign mem_req   = waitSt;
  assign mem_we    = MemWriteM;
  assign mem_addr  = ALUOutM;
  assign mem_wdata = WriteDataM;

  // Whenever EX/MEM takes a new instruction the FSM follows that instruction.
  always_comb begin
    stateNext = state;
    if (!StallM)
      stateNext = alignAccE ? WAIT : IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      if (StallM)
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      MemtoRegM  <= 2'b00;
      jumpM      <= 1'b0;
      WriteRegM  <= 5'd0;
      ALUOutM    <= 32'd0;
      WriteDataM <= 32'd0;
      PCPlus4M   <= 32'd0;
    end else if (!StallM) begin
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      MemtoRegM  <= MemtoRegE;
      jumpM      <= jumpE;
      WriteRegM  <= WriteRegE;
      ALUOutM    <= ALUMultOutE;
      WriteDataM <= WriteDataE;
      PCPlus4M   <= PCPlus4E;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWriteW <= 1'b0;
      jumpW     <= 1'b0;
      MemtoRegW <= 2'b00;
      WriteRegW <= 5'd0;
      ALUOutW   <= 32'd0;
      ReadDataW <= 32'd0;
      PCPlus4W  <= 32'd0;
      MemErr    <= 2'b00;
    end else if (StallM || abortM) begin
      RegWriteW <= 1'b0;
      jumpW     <= 1'b0;
      if (abortM)
        MemErr[1] <= 1'b1;
    end else begin
      // IDLE here means the M instruction is a non-access or misaligned.
      RegWriteW <= RegWriteM & ~misM;
      jumpW     <= jumpM;
      MemtoRegW <= MemtoRegM;
      WriteRegW <= WriteRegM;
      ALUOutW   <= ALUOutM;
      PCPlus4W  <= PCPlus4M;
      if (misM)
        MemErr[0] <= 1'b1;
      if (waitSt && !MemWriteM)
        ReadDataW <= mem_rdata;
    end
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
Pipeline stage directly downstream of the execute stage in the 5-stage MIPS core.
- Holds the EX/MEM pipeline register.
- Runs word load/store accesses to the data memory over a req/ready handshake with stall generation, timeout and misalignment detection.
- Holds the MEM/WB pipeline register that feeds writeback.
- Supplies ALUOutM to execute-stage forwarding and StallM to the hazard unit.

Parameters:
TIMEOUT, 16, max WAIT cycles without mem_ready before the access is aborted (>=2)
CNT_W, 5, width of wait counter (must hold TIMEOUT)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
RegWriteE  in  1  register write enable from execute
MemWriteE  in  1  store enable from execute
MemtoRegE  in  2  WB source: 00 ALU/mult result, 01 load data, 1x mult result (already folded into ALUMultOutE)
jumpE  in  1  jump/link flag from execute
WriteRegE  in  5  destination register from execute
ALUMultOutE  in  32  ALU/multiplier result = memory address for load/store
WriteDataE  in  32  store data (already forwarded)
PCPlus4E  in  32  PC+4 from execute
ALUOutM  out  32  EX/MEM result, used for forwarding
WriteRegM  out  5  EX/MEM destination, to hazard unit
RegWriteM  out  1  EX/MEM write enable, to hazard unit
MemtoRegM  out  2  EX/MEM WB source, to hazard unit
StallM  out  1  hold request to hazard unit (freezes F/D/E and this stage)
mem_req  out  1  data memory request
mem_we  out  1  1 = store, 0 = load
mem_addr  out  32  word address (byte address, bits[1:0]=0)
mem_wdata  out  32  store data
mem_ready  in  1  memory accepts/completes the access this cycle
mem_rdata  in  32  load data, valid when mem_ready
RegWriteW, jumpW  out  1  MEM/WB flags
MemtoRegW  out  2  MEM/WB WB source
WriteRegW  out  5  MEM/WB destination
ALUOutW, ReadDataW, PCPlus4W  out  32  MEM/WB data
MemErr  out  2  sticky: [1] timeout, [0] misaligned

Behaviour:
- One clock domain (clk), rst asynchronous active-high. On rst every register and output listed goes to 0, FSM to IDLE, counter to 0; mem_req drops immediately, including mid-access.
- MemAccessE = MemWriteE | (MemtoRegE==2'b01). MisalignE = MemAccessE & (ALUMultOutE[1:0]!=0).
- EX/MEM register loads all E inputs every edge unless StallM=1, in which case it holds.
- FSM states:
  - IDLE → WAIT on an edge where the EX/MEM register loads an instruction with MemAccessE & !MisalignE.
  - WAIT & mem_ready → IDLE, or WAIT again if the newly loaded instruction is also an aligned access.
  - WAIT & !mem_ready & cnt==TIMEOUT-1 → IDLE (abort).
- mem_req = (state==WAIT). mem_we, mem_addr, mem_wdata are driven from the EX/MEM register and stable while mem_req=1.
- StallM = WAIT & !mem_ready & !(cnt==TIMEOUT-1).
- Counter: cleared on entry to WAIT, increments each WAIT cycle without mem_ready.
- MEM/WB register updates every edge:
  - Access completing (mem_ready) or no-access instruction: copy EX/MEM fields; ReadDataW <= mem_rdata on a load, otherwise unchanged.
  - StallM=1: bubble (RegWriteW=0, jumpW=0, other W fields hold).
  - Abort: bubble, MemErr[1] set.
  - Misaligned instruction: passes to W with RegWriteW forced 0, no memory request, MemErr[0] set, no stall.
- With zero-wait memory (mem_ready tied 1) a load reaches W one cycle after M with no stall; throughput is 1 instr/cycle.
- A store never writes a register; RegWriteW follows RegWriteE unchanged for stores.
- MemErr bits clear only on rst.

Test Plan:
- ALU op (MemtoRegE=00, ALUMultOutE=0x1234, WriteRegE=5, RegWriteE=1) → ALUOutM=0x1234 next cycle, W next after with RegWriteW=1, WriteRegW=5; mem_req stays 0.
- Load addr 0x40, mem_ready=1 in first WAIT cycle, mem_rdata=0xDEADBEEF → mem_req 1 cycle, StallM=0 throughout, ReadDataW=0xDEADBEEF, RegWriteW=1.
- Store addr 0x80 data 0xA5A5A5A5, mem_ready delayed 3 cycles → mem_req, mem_we=1, addr and data stable 4 cycles; StallM=1 for 3 cycles; 3 W bubbles; following instruction enters M only after ready.
- Back-to-back loads 0x0, 0x4 with mem_ready=1 → two consecutive mem_req cycles with addresses 0x0 then 0x4, no stall.
- Load addr 0x42 → no mem_req, MemErr=2'b01, RegWriteW=0; and load with mem_ready never asserted, TIMEOUT=16 → StallM high 15 cycles, abort, MemErr[1]=1, pipeline resumes.
- rst asserted during WAIT → mem_req, StallM and all outputs 0 immediately; FSM IDLE after release.
